// File: rtl/decode_pipe.sv
// Decode stage: IF/ID and ID/EX registers, register file with write bypass,
// branch/jump resolution with redirect. Define DECODE_BNE_EN to decode bne.
module decode_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned RA_W = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc4,
  output logic            id_ready,
  input  logic            hz_stall,
  input  logic            fwd_a,
  input  logic            fwd_b,
  input  logic [XLEN-1:0] mem_alu_out,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            redir,
  output logic [XLEN-1:0] redir_pc,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [6:0]      ex_ctrl,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs,
  output logic [RA_W-1:0] ex_rt,
  output logic [RA_W-1:0] ex_dst,
  output logic            ex_syscall
);

  logic            ifid_valid;
  logic [31:0]     ifid_instr;
  logic [XLEN-1:0] ifid_pc4;
  logic [XLEN-1:0] regs [NREGS];

  logic [5:0]      op, funct;
  logic [RA_W-1:0] rs, rt, rd;
  logic [XLEN-1:0] rd_a, rd_b, cmp_a, cmp_b, imm_sx, target;
  logic [XLEN-1:0] a_next, imm_next;
  logic [6:0]      ctrl;
  logic [RA_W-1:0] dst;
  logic            syscall, is_beq, is_bne, is_j, is_jal, is_jr, taken;

  assign id_ready = !hz_stall && (!ex_valid || ex_ready);

  assign op     = ifid_instr[31:26];
  assign funct  = ifid_instr[5:0];
  assign rs     = RA_W'(ifid_instr[25:21]);
  assign rt     = RA_W'(ifid_instr[20:16]);
  assign rd     = RA_W'(ifid_instr[15:11]);
  assign imm_sx = {{(XLEN-16){ifid_instr[15]}}, ifid_instr[15:0]};

  // Register reads see a same-cycle writeback to the same address.
  always_comb begin
    if (rs == '0)                      rd_a = '0;
    else if (wb_we && wb_addr == rs)   rd_a = wb_data;
    else                               rd_a = regs[rs];
    if (rt == '0)                      rd_b = '0;
    else if (wb_we && wb_addr == rt)   rd_b = wb_data;
    else                               rd_b = regs[rt];
  end

  always_comb begin
    ctrl    = '0;
    dst     = '0;
    syscall = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: begin ctrl = 7'b1000010; dst = rd; end
          6'b100010: begin ctrl = 7'b1000110; dst = rd; end
          6'b100100: begin ctrl = 7'b1000000; dst = rd; end
          6'b100101: begin ctrl = 7'b1000001; dst = rd; end
          6'b101010: begin ctrl = 7'b1000111; dst = rd; end
          6'b001000: begin is_jr = 1'b1; dst = rd; end
          6'b001100: begin syscall = 1'b1; dst = rd; end
          default: ;
        endcase
      end
      6'b100011: begin ctrl = 7'b1101010; dst = rt; end
      6'b101011: ctrl = 7'b0011010;
      6'b001000: begin ctrl = 7'b1001010; dst = rt; end
      6'b000100: begin ctrl = 7'b0000110; is_beq = 1'b1; end
`ifdef DECODE_BNE_EN
      6'b000101: begin ctrl = 7'b0000110; is_bne = 1'b1; end
`endif
      6'b000010: is_j = 1'b1;
      6'b000011: begin ctrl = 7'b1001010; dst = RA_W'(31); is_jal = 1'b1; end
      default: ;
    endcase
  end

  assign cmp_a = fwd_a ? mem_alu_out : rd_a;
  assign cmp_b = fwd_b ? mem_alu_out : rd_b;
  assign taken = (is_beq && cmp_a == cmp_b) || (is_bne && cmp_a != cmp_b);

  always_comb begin
    if (is_jr)
      target = cmp_a;
    else if (is_j || is_jal)
      target = {ifid_pc4[XLEN-1:28], ifid_instr[25:0], 2'b00};
    else
      target = ifid_pc4 + (imm_sx << 2);
  end

  assign redir    = ifid_valid && id_ready && (taken || is_j || is_jal || is_jr);
  assign redir_pc = redir ? target : '0;

  // jal carries its link address through the ALU as pc4 + 4 + 0.
  assign a_next   = is_jal ? ifid_pc4 + XLEN'(4) : rd_a;
  assign imm_next = is_jal ? '0 : imm_sx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (id_ready) begin
      ifid_valid <= if_valid && !redir;
      ifid_instr <= if_instr;
      ifid_pc4   <= if_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dst     <= '0;
      ex_syscall <= 1'b0;
    end else if (id_ready) begin
      ex_valid   <= ifid_valid;
      ex_ctrl    <= ctrl;
      ex_a       <= a_next;
      ex_b       <= rd_b;
      ex_imm     <= imm_next;
      ex_rs      <= rs;
      ex_rt      <= rt;
      ex_dst     <= dst;
      ex_syscall <= syscall;
    end else if (hz_stall && ex_ready) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_syscall <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe; expected values are hand-computed encodings.
module tb_decode_pipe;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc4;
  logic            id_ready;
  logic            hz_stall, fwd_a, fwd_b;
  logic [XLEN-1:0] mem_alu_out;
  logic            wb_we;
  logic [RA_W-1:0] wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            redir;
  logic [XLEN-1:0] redir_pc;
  logic            ex_valid, ex_ready;
  logic [6:0]      ex_ctrl;
  logic [XLEN-1:0] ex_a, ex_b, ex_imm;
  logic [RA_W-1:0] ex_rs, ex_rt, ex_dst;
  logic            ex_syscall;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  decode_pipe #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4), .id_ready(id_ready),
    .hz_stall(hz_stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_alu_out(mem_alu_out),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .redir(redir), .redir_pc(redir_pc),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_syscall(ex_syscall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [RA_W-1:0] addr, input logic [XLEN-1:0] data);
    wb_we = 1'b1; wb_addr = addr; wb_data = data;
    step();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc4 = '0;
    hz_stall = 1'b0; fwd_a = 1'b0; fwd_b = 1'b0; mem_alu_out = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
    #3;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_ctrl", ex_ctrl, 0);
    check("rst_id_ready", id_ready, 1);
    check("rst_redir", redir, 0);
    @(negedge clk) rst_n = 1'b1;

    // addi r1,r0,5
    if_valid = 1'b1; if_instr = 32'h2001_0005; if_pc4 = 32'h4;
    step();
    if_valid = 1'b0;
    step();
    check("addi_valid", ex_valid, 1);
    check("addi_ctrl", ex_ctrl, 7'b1001010);
    check("addi_dst", ex_dst, 1);
    check("addi_imm", ex_imm, 5);
    wb_write(5'd1, 32'd5);
    wb_write(5'd3, 32'd7);
    wb_write(5'd4, 32'd9);

    // beq r3,r4,+4 at pc4 0x100
    if_valid = 1'b1; if_instr = 32'h1064_0004; if_pc4 = 32'h100;
    step();
    if_instr = 32'h2001_0005; if_pc4 = 32'h104;
    #1;
    check("beq_nofwd_redir", redir, 0);
    fwd_a = 1'b1; mem_alu_out = 32'd9;
    #1;
    check("beq_redir", redir, 1);
    check("beq_redir_pc", redir_pc, 32'h110);
    step();
    fwd_a = 1'b0; mem_alu_out = '0; if_valid = 1'b0;
    check("beq_ex_valid", ex_valid, 1);
    check("beq_regwrite", ex_ctrl[6], 0);
    #1;
    check("squash_redir", redir, 0);
    step();
    check("squash_ex_valid", ex_valid, 0);

    // lw r5,8(r2) while r2 is written on the same edge
    if_valid = 1'b1; if_instr = 32'h8C45_0008; if_pc4 = 32'h200;
    step();
    if_valid = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEAD_0000;
    step();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    check("lw_bypass_a", ex_a, 32'hDEAD_0000);
    check("lw_ctrl", ex_ctrl, 7'b1101010);
    check("lw_dst", ex_dst, 5);
    check("lw_imm", ex_imm, 8);

    // r0 ignores writes; add r6,r0,r2 then jal 0x40 behind it
    wb_write(5'd0, 32'h1234);
    if_valid = 1'b1; if_instr = 32'h0002_3020; if_pc4 = 32'h300;
    step();
    if_instr = 32'h0C00_0040; if_pc4 = 32'h2004;
    step();
    check("add_ctrl", ex_ctrl, 7'b1000010);
    check("add_r0_a", ex_a, 0);
    check("add_b", ex_b, 32'hDEAD_0000);
    check("add_dst", ex_dst, 6);

    // Back-pressure from EX
    ex_ready = 1'b0; if_instr = 32'hFC00_0000; if_pc4 = 32'h3000;
    #1;
    check("bp_id_ready", id_ready, 0);
    check("bp_redir", redir, 0);
    repeat (3) step();
    check("bp_ex_valid", ex_valid, 1);
    check("bp_ex_dst", ex_dst, 6);
    check("bp_ex_b", ex_b, 32'hDEAD_0000);
    ex_ready = 1'b1; hz_stall = 1'b1;
    step();
    check("hz_bubble", ex_valid, 0);
    hz_stall = 1'b0; if_valid = 1'b0;
    #1;
    check("jal_redir", redir, 1);
    check("jal_redir_pc", redir_pc, 32'h100);
    step();
    check("jal_ex_a", ex_a, 32'h2008);
    check("jal_dst", ex_dst, 31);
    check("jal_ctrl", ex_ctrl, 7'b1001010);
    check("jal_imm", ex_imm, 0);

    // Unknown opcode
    if_valid = 1'b1; if_instr = 32'hFC22_1800; if_pc4 = 32'h500;
    step();
    if_valid = 1'b0;
    step();
    check("bad_ctrl", ex_ctrl, 0);
    check("bad_dst", ex_dst, 0);

    // bne r0,r1 with r1=1
    wb_write(5'd1, 32'd1);
    if_valid = 1'b1; if_instr = 32'h1401_0000; if_pc4 = 32'h400;
    step();
    if_valid = 1'b0;
    #1;
`ifdef DECODE_BNE_EN
    check("bne_redir", redir, 1);
    check("bne_redir_pc", redir_pc, 32'h400);
    step();
    check("bne_regwrite", ex_ctrl[6], 0);
`else
    check("bne_redir", redir, 0);
    check("bne_redir_pc", redir_pc, 0);
    step();
    check("bne_ctrl", ex_ctrl, 0);
`endif
    check("bne_ex_valid", ex_valid, 1);

    // Asynchronous reset mid-cycle clears pipeline and register file
    #2 rst_n = 1'b0;
    #1;
    check("arst_ex_valid", ex_valid, 0);
    check("arst_ex_a", ex_a, 0);
    check("arst_ex_dst", ex_dst, 0);
    @(negedge clk) rst_n = 1'b1;
    if_valid = 1'b1; if_instr = 32'h0002_3020; if_pc4 = 32'h600;
    step();
    if_valid = 1'b0;
    step();
    check("arst_regs_b", ex_b, 0);
    check("arst_add_valid", ex_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
